regfile_write_arbiter: RTL and testbench

//  Shares the single regfile write port (we3/wa3/wd3) between the pipeline writeback stage and the

---
 rtl/cpu_pkg.sv | 16 +
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 46 ++++
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 tb/tb_regfile_write_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the regfile write arbiter,
// its interface and its scoreboard.
package cpu_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  // Grant mode for the current cycle, decoded from the starvation counter.
  typedef enum logic {
    ARB_NORMAL,
    ARB_FORCE_MC
  } arb_state_e;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request/grant and regfile write-port bundle between the writeback stage,
// the multi-cycle unit, the arbiter and the regfile.
interface regfile_write_arbiter_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
);
  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_wa;
  logic [DATA_W-1:0]   wb_wd;
  logic                wb_ready;
  logic                mc_valid;
  logic [ADDR_W-1:0]   mc_wa;
  logic [DATA_W-1:0]   mc_wd;
  logic                mc_ready;
  logic                mc_issue;
  logic [ADDR_W-1:0]   mc_issue_wa;
  logic                we3;
  logic [ADDR_W-1:0]   wa3;
  logic [DATA_W-1:0]   wd3;
  logic [NUM_REGS-1:0] pending;
  logic                sb_error;

  modport master (
    output wb_valid, wb_wa, wb_wd, mc_valid, mc_wa, mc_wd, mc_issue, mc_issue_wa,
    input  wb_ready, mc_ready, we3, wa3, wd3, pending, sb_error
  );

  modport slave (
    input  wb_valid, wb_wa, wb_wd, mc_valid, mc_wa, mc_wd, mc_issue, mc_issue_wa,
    output wb_ready, mc_ready, we3, wa3, wd3, pending, sb_error
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for multi-cycle results: one bit per register,
// set on issue, cleared on writeback, plus a sticky protocol error flag.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue,
  input  logic [ADDR_W-1:0]   issue_wa,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   wr_wa,
  output logic [NUM_REGS-1:0] pending,
  output logic                sb_error
);
  logic                issue_ok;
  logic                wr_ok;
  logic                err_now;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  assign issue_ok = issue && (issue_wa != ADDR_W'(ZERO_REG));
  assign wr_ok    = wr && (wr_wa != ADDR_W'(ZERO_REG));
  assign err_now  = (issue_ok && pending[issue_wa]) || (wr_ok && !pending[wr_wa]);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_ok) set_vec[issue_wa] = 1'b1;
    if (wr)       clr_vec[wr_wa]    = 1'b1;
  end

  // Set is applied after clear so a same-cycle re-issue keeps the register pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      sb_error <= 1'b0;
    end else begin
      pending  <= (pending & ~clr_vec) | set_vec;
      sb_error <= sb_error | err_now;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single regfile write port between pipeline writeback (priority)
// and the multi-cycle unit, with a starvation guard and registered write port.
module regfile_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W       = cpu_pkg::DATA_W,
  parameter int ADDR_W       = cpu_pkg::ADDR_W,
  parameter int ZERO_REG     = cpu_pkg::ZERO_REG,
  parameter int STARVE_LIMIT = 4
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_nxt;
  logic              wb_ready;
  logic              mc_ready;
  logic              wb_xfer;
  logic              mc_xfer;
  logic              win_valid;
  logic [ADDR_W-1:0] win_wa;
  logic [DATA_W-1:0] win_wd;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;

  // The counter is the only state; FORCE_MC is only meaningful while mc is asking.
  always_comb begin
    state          = ARB_NORMAL;
    wb_ready       = 1'b0;
    mc_ready       = 1'b0;
    starve_cnt_nxt = starve_cnt;
    if (bus.mc_valid && (starve_cnt == CNT_W'(STARVE_LIMIT))) state = ARB_FORCE_MC;
    if (!reset) begin
      case (state)
        ARB_NORMAL: begin
          wb_ready = 1'b1;
          mc_ready = !bus.wb_valid;
        end
        ARB_FORCE_MC: mc_ready = 1'b1;
        default: ;
      endcase
    end
    if (!bus.mc_valid || (bus.mc_valid && mc_ready)) starve_cnt_nxt = '0;
    else if (starve_cnt != CNT_W'(STARVE_LIMIT))     starve_cnt_nxt = starve_cnt + 1'b1;
  end

  assign wb_xfer   = bus.wb_valid && wb_ready;
  assign mc_xfer   = bus.mc_valid && mc_ready;
  assign win_valid = wb_xfer || mc_xfer;
  assign win_wa    = wb_xfer ? bus.wb_wa : bus.mc_wa;
  assign win_wd    = wb_xfer ? bus.wb_wd : bus.mc_wd;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      we3        <= win_valid && (win_wa != ADDR_W'(ZERO_REG));
      // XZR writes are accepted but leave the address/data registers untouched.
      if (win_valid && (win_wa != ADDR_W'(ZERO_REG))) begin
        wa3 <= win_wa;
        wd3 <= win_wd;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .issue    (bus.mc_issue),
    .issue_wa (bus.mc_issue_wa),
    .wr       (mc_xfer),
    .wr_wa    (bus.mc_wa),
    .pending  (bus.pending),
    .sb_error (bus.sb_error)
  );

  assign bus.wb_ready = wb_ready;
  assign bus.mc_ready = mc_ready;
  assign bus.we3      = we3;
  assign bus.wa3      = wa3;
  assign bus.wd3      = wd3;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_regfile_write_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;

  regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) arb_if ();

  regfile_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (arb_if)
  );

  always #5 clk = ~clk;

  // Downstream regfile fed by the arbiter's write port.
  logic [63:0] rf [32];
  always @(posedge clk) if (arb_if.we3) rf[arb_if.wa3] <= arb_if.wd3;

  // Reference model state.
  int          denied;
  logic [31:0] m_pend;
  logic        m_err, m_we, m_xzr;
  logic [4:0]  m_wa;
  logic [63:0] m_wd;
  logic [63:0] m_rf [32];
  bit          last_wb_acc, last_mc_acc, obs_mc_ready;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    arb_if.wb_valid    = 1'b0;
    arb_if.wb_wa       = '0;
    arb_if.wb_wd       = '0;
    arb_if.mc_valid    = 1'b0;
    arb_if.mc_wa       = '0;
    arb_if.mc_wd       = '0;
    arb_if.mc_issue    = 1'b0;
    arb_if.mc_issue_wa = '0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    bit          forced, e_wb_r, e_mc_r, wbx, mcx, win;
    logic [4:0]  w_wa;
    logic [63:0] w_wd;
    #1;
    forced = arb_if.mc_valid && (denied >= STARVE_LIMIT);
    e_wb_r = !reset && !forced;
    e_mc_r = !reset && (forced || !arb_if.wb_valid);
    check("wb_ready", 64'(arb_if.wb_ready), 64'(e_wb_r));
    check("mc_ready", 64'(arb_if.mc_ready), 64'(e_mc_r));
    obs_mc_ready = arb_if.mc_ready;
    wbx = arb_if.wb_valid && e_wb_r;
    mcx = arb_if.mc_valid && e_mc_r;
    last_wb_acc = wbx;
    last_mc_acc = mcx;
    if (reset) begin
      denied = 0; m_pend = '0; m_err = 1'b0; m_we = 1'b0; m_xzr = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      if (!arb_if.mc_valid || mcx) denied = 0;
      else if (denied < STARVE_LIMIT) denied++;
      win   = wbx || mcx;
      w_wa  = wbx ? arb_if.wb_wa : arb_if.mc_wa;
      w_wd  = wbx ? arb_if.wb_wd : arb_if.mc_wd;
      m_xzr = win && (w_wa == 5'd31);
      m_we  = win && !m_xzr;
      if (m_we) begin
        m_wa = w_wa; m_wd = w_wd; m_rf[w_wa] = w_wd;
      end
      if (arb_if.mc_issue && arb_if.mc_issue_wa != 5'd31 && m_pend[arb_if.mc_issue_wa]) m_err = 1'b1;
      if (mcx && arb_if.mc_wa != 5'd31 && !m_pend[arb_if.mc_wa]) m_err = 1'b1;
      if (mcx) m_pend[arb_if.mc_wa] = 1'b0;
      if (arb_if.mc_issue && arb_if.mc_issue_wa != 5'd31) m_pend[arb_if.mc_issue_wa] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("we3", 64'(arb_if.we3), 64'(m_we));
    if (!m_xzr) begin
      check("wa3", 64'(arb_if.wa3), 64'(m_wa));
      check("wd3", arb_if.wd3, m_wd);
    end
    check("pending", 64'(arb_if.pending), 64'(m_pend));
    check("sb_error", 64'(arb_if.sb_error), 64'(m_err));
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_mc_wa();
    int s;
    if (m_pend != '0 && ($urandom % 4) != 0) begin
      s = int'($urandom % 32);
      for (int k = 0; k < 32; k++)
        if (m_pend[(s + k) % 32]) return 5'((s + k) % 32);
    end
    return 5'($urandom % 32);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int denials;
    for (int r = 0; r < 32; r++) begin
      rf[r]   = '0;
      m_rf[r] = '0;
    end
    denied = 0; m_pend = '0; m_err = 1'b0; m_we = 1'b0; m_xzr = 1'b0; m_wa = '0; m_wd = '0;

    // Reset held for two cycles with every request line active.
    reset = 1'b1;
    arb_if.wb_valid = 1'b1; arb_if.wb_wa = 5'd3; arb_if.wb_wd = 64'd1;
    arb_if.mc_valid = 1'b1; arb_if.mc_wa = 5'd3; arb_if.mc_wd = 64'd2;
    arb_if.mc_issue = 1'b1; arb_if.mc_issue_wa = 5'd3;
    cycle();
    cycle();

    // Solo pipeline write lands in x5.
    reset = 1'b0;
    idle(); arb_if.wb_valid = 1'b1; arb_if.wb_wa = 5'd5; arb_if.wb_wd = 64'd35;
    cycle();
    idle();
    cycle();
    check("rf_x5", rf[5], 64'd35);

    // Starvation: mc denied STARVE_LIMIT times, then forced through.
    idle(); arb_if.mc_issue = 1'b1; arb_if.mc_issue_wa = 5'd9;
    cycle();
    denials = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      arb_if.wb_valid = 1'b1; arb_if.wb_wa = 5'(i + 1); arb_if.wb_wd = 64'(100 + i);
      arb_if.mc_valid = 1'b1; arb_if.mc_wa = 5'd9; arb_if.mc_wd = 64'd77;
      cycle();
      if (!obs_mc_ready) denials++;
    end
    check("starve_denials", 64'(denials), 64'd4);
    check("starve_wa3", 64'(arb_if.wa3), 64'd9);
    check("starve_pend9", 64'(arb_if.pending[9]), 64'd0);
    arb_if.mc_valid = 1'b0;
    cycle();

    // XZR: accepted but never written, never marked pending.
    idle(); arb_if.wb_valid = 1'b1; arb_if.wb_wa = 5'd31; arb_if.wb_wd = 64'hdead;
    cycle();
    check("xzr_we3", 64'(arb_if.we3), 64'd0);
    idle(); arb_if.mc_issue = 1'b1; arb_if.mc_issue_wa = 5'd31;
    cycle();
    check("xzr_sb_error", 64'(arb_if.sb_error), 64'd0);

    // Scoreboard: issue, double issue, same-cycle clear and re-issue.
    idle(); arb_if.mc_issue = 1'b1; arb_if.mc_issue_wa = 5'd12;
    cycle();
    cycle();
    check("double_issue_err", 64'(arb_if.sb_error), 64'd1);
    idle();
    arb_if.mc_valid = 1'b1; arb_if.mc_wa = 5'd12; arb_if.mc_wd = 64'd55;
    arb_if.mc_issue = 1'b1; arb_if.mc_issue_wa = 5'd12;
    cycle();
    check("set_wins_pend12", 64'(arb_if.pending[12]), 64'd1);

    // Reset arriving in the forced-mc cycle.
    idle();
    arb_if.wb_valid = 1'b1; arb_if.wb_wa = 5'd4; arb_if.wb_wd = 64'd44;
    arb_if.mc_valid = 1'b1; arb_if.mc_wa = 5'd12; arb_if.mc_wd = 64'd66;
    for (int i = 0; i < 4; i++) cycle();
    reset = 1'b1;
    cycle();
    check("midrst_starve_cnt", 64'(dut.starve_cnt), 64'd0);
    reset = 1'b0;
    arb_if.wb_wa = 5'd7; arb_if.wb_wd = 64'd70;
    cycle();
    check("post_rst_wa3", 64'(arb_if.wa3), 64'd7);

    // Random traffic with requesters holding until accepted.
    idle();
    for (int n = 0; n < 400; n++) begin
      if (!(arb_if.wb_valid && !last_wb_acc)) begin
        arb_if.wb_valid = ($urandom % 3) != 0;
        arb_if.wb_wa    = 5'($urandom % 32);
        arb_if.wb_wd    = {$urandom, $urandom};
      end
      if (!(arb_if.mc_valid && !last_mc_acc)) begin
        arb_if.mc_valid = ($urandom % 2) != 0;
        arb_if.mc_wa    = pick_mc_wa();
        arb_if.mc_wd    = {$urandom, $urandom};
      end
      arb_if.mc_issue    = ($urandom % 10) < 3;
      arb_if.mc_issue_wa = 5'($urandom % 32);
      reset = ($urandom % 64) == 0;
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();
    cycle();
    for (int r = 0; r < 31; r++) check($sformatf("rf_x%0d", r), rf[r], m_rf[r]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
